roulette_round_controller: RTL

Round sequencer for the roulette games. It owns the player balance. It sequences each spin: start, spin delay, sample random number, judge, pay out, show result. It selects the scoring rule by mode: exact-number guess or even/odd guess. It detects game-over (won/lost) and drives the result LEDs. It sits between the board switches/keys, the random-number source and the HEX/LED display logic.

---
 rtl/roulette_round_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/roulette_round_controller.sv
`timescale 1ns/1ps
// Roulette round sequencer: owns the player balance, times spin/show/flash phases,
// judges each spin in exact-number or even/odd mode and drives the result LEDs.
module roulette_round_controller #(
  parameter int unsigned START_BALANCE = 10,
  parameter int unsigned WIN_THRESHOLD = 20,
  parameter int unsigned PAYOUT_EO     = 2,
  parameter int unsigned PAYOUT_EXACT  = 8,
  parameter int unsigned LOSS          = 1,
  parameter int unsigned SPIN_CYCLES   = 25000000,
  parameter int unsigned SHOW_CYCLES   = 50000000,
  parameter int unsigned FLASH_CYCLES  = 12500000
) (
  input  logic       Clock,
  input  logic       reset_n,
  input  logic       startGame,
  input  logic       mode_sel,
  input  logic [4:0] playerGuess,
  input  logic [4:0] randnum,
  output logic [4:0] playerBalance,
  output logic [4:0] result_num,
  output logic [4:0] fsm_out,
  output logic       busy,
  output logic       game_over
);

  localparam int unsigned BAL_W   = 5;
  localparam int unsigned ARITH_W = BAL_W + 1;
  localparam int unsigned CNT_A   = (SPIN_CYCLES > SHOW_CYCLES) ? SPIN_CYCLES : SHOW_CYCLES;
  localparam int unsigned CNT_MAX = (CNT_A > FLASH_CYCLES) ? CNT_A : FLASH_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   SPIN_LOAD  = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [BAL_W-1:0]   BAL_START  = BAL_W'(START_BALANCE);
  localparam logic [ARITH_W-1:0] BAL_MAX    = ARITH_W'(31);
  localparam logic [ARITH_W-1:0] WIN_LVL    = ARITH_W'(WIN_THRESHOLD);
  localparam logic [ARITH_W-1:0] PAY_EO     = ARITH_W'(PAYOUT_EO);
  localparam logic [ARITH_W-1:0] PAY_EXACT  = ARITH_W'(PAYOUT_EXACT);
  localparam logic [ARITH_W-1:0] LOSS_AMT   = ARITH_W'(LOSS);

  localparam logic [4:0] LED_OFF  = 5'b00000;
  localparam logic [4:0] LED_SPIN = 5'b00100;
  localparam logic [4:0] LED_HIT  = 5'b00001;
  localparam logic [4:0] LED_MISS = 5'b00010;
  localparam logic [4:0] LED_WON  = 5'b11111;
  localparam logic [4:0] LED_LOST = 5'b10101;

  typedef enum logic [2:0] {
    S_IDLE, S_SPIN, S_JUDGE, S_SHOW, S_WON, S_LOST
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               start_q;
  logic               mode_q, mode_d;
  logic [4:0]         guess_q, guess_d;
  logic               hit_q, hit_d;
  logic               flash_q, flash_d;
  logic [BAL_W-1:0]   bal_d;
  logic [4:0]         result_d;
  logic [4:0]         fsm_out_d;
  logic               busy_d, game_over_d;

  logic               start_rise_c;
  logic               hit_c;
  logic [ARITH_W-1:0] sum_c, new_bal_c;

  assign start_rise_c = startGame & ~start_q;

  // State and all registered outputs.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      start_q       <= 1'b0;
      mode_q        <= 1'b0;
      guess_q       <= '0;
      hit_q         <= 1'b0;
      flash_q       <= 1'b0;
      playerBalance <= BAL_START;
      result_num    <= '0;
      fsm_out       <= LED_OFF;
      busy          <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      start_q       <= startGame;
      mode_q        <= mode_d;
      guess_q       <= guess_d;
      hit_q         <= hit_d;
      flash_q       <= flash_d;
      playerBalance <= bal_d;
      result_num    <= result_d;
      fsm_out       <= fsm_out_d;
      busy          <= busy_d;
      game_over     <= game_over_d;
    end
  end

  // Judge arithmetic: 6-bit wide so the payout sum can saturate at 31.
  always_comb begin
    sum_c     = {1'b0, playerBalance} + (mode_q ? PAY_EXACT : PAY_EO);
    hit_c     = mode_q ? (result_num == guess_q) : (result_num[0] == ~guess_q[0]);
    new_bal_c = '0;
    if (hit_c) begin
      new_bal_c = (sum_c > BAL_MAX) ? BAL_MAX : sum_c;
    end else if ({1'b0, playerBalance} > LOSS_AMT) begin
      new_bal_c = {1'b0, playerBalance} - LOSS_AMT;
    end
  end

  // Next-state, counter and datapath updates.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    mode_d   = mode_q;
    guess_d  = guess_q;
    hit_d    = hit_q;
    flash_d  = flash_q;
    bal_d    = playerBalance;
    result_d = result_num;
    case (state)
      S_IDLE: begin
        if (start_rise_c) begin
          mode_d  = mode_sel;
          guess_d = playerGuess;
          cnt_d   = SPIN_LOAD;
          state_d = S_SPIN;
        end
      end
      S_SPIN: begin
        if (cnt == '0) begin
          result_d = randnum;
          state_d  = S_JUDGE;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      S_JUDGE: begin
        hit_d = hit_c;
        bal_d = new_bal_c[BAL_W-1:0];
        if (new_bal_c >= WIN_LVL) begin
          flash_d = 1'b1;
          cnt_d   = FLASH_LOAD;
          state_d = S_WON;
        end else if (new_bal_c == '0) begin
          state_d = S_LOST;
        end else begin
          cnt_d   = SHOW_LOAD;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      S_WON: begin
        if (start_rise_c) begin
          bal_d   = BAL_START;
          state_d = S_IDLE;
        end else if (cnt == '0) begin
          flash_d = ~flash_q;
          cnt_d   = FLASH_LOAD;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      S_LOST: begin
        if (start_rise_c) begin
          bal_d   = BAL_START;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered, registered alongside it.
  always_comb begin
    fsm_out_d   = LED_OFF;
    busy_d      = 1'b0;
    game_over_d = 1'b0;
    case (state_d)
      S_SPIN, S_JUDGE: begin
        fsm_out_d = LED_SPIN;
        busy_d    = 1'b1;
      end
      S_SHOW: begin
        fsm_out_d = hit_d ? LED_HIT : LED_MISS;
        busy_d    = 1'b1;
      end
      S_WON: begin
        fsm_out_d   = flash_d ? LED_WON : LED_OFF;
        game_over_d = 1'b1;
      end
      S_LOST: begin
        fsm_out_d   = LED_LOST;
        game_over_d = 1'b1;
      end
      default: fsm_out_d = LED_OFF;
    endcase
  end

endmodule
